weight_tile_sched: RTL and testbench

Tile scheduler for the convolution layer's weight path. It walks the output-channel tiles and input-channel tiles of one layer. For each tile it configures and enables the weight memory controller with a start row and a row count, then waits a fixed load window. It then hands the loaded kernels to the PE array through a start/done handshake. It sits between the layer-level top controller and the weight memory controller / PE array.

---
 rtl/weight_tile_sched.sv | 180 ++++++++++++++++++
 tb/tb_weight_tile_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_sched.sv
// weight_tile_sched
//   Walks the (output-channel, input-channel) tiles of one convolution layer.
//   For every tile it enables the weight memory controller with a start row,
//   gives it a fixed load window, then hands the tile to the PE array through
//   a compute_start / compute_done handshake. n (input tiles) is the inner
//   loop, m (output tiles) the outer loop.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle layer request, honoured only when idle
//   abort             synchronous abort back to idle, highest priority
//   cfg_base_addr     first weight-memory row of the layer
//   cfg_n_tiles       input-channel tiles per output tile
//   cfg_m_tiles       output-channel tiles
//   compute_done      PE array finished the current tile
//   wload_state       enable to the weight memory controller
//   wload_init_addr   start row of the current tile
//   wload_amount      rows per tile (constant TILE_ROWS)
//   compute_start     one-cycle pulse, weights are stable
//   acc_first         current tile is the first input tile (n == 0)
//   acc_last          current tile is the last input tile
//   busy              high whenever not idle
//   layer_done        one-cycle pulse when the layer completes
//
// Build option
//   WEIGHT_TILE_SCHED_ACC_FLAGS_EN: when defined, acc_first/acc_last are
//   driven (updated together with compute_start); otherwise tied to 0.

module weight_tile_sched #(
  parameter int Tn        = 4,
  parameter int Tm        = 8,
  parameter int LOAD_WAIT = 40   // must be >= Tn*Tm + 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] cfg_base_addr,
  input  logic [7:0] cfg_n_tiles,
  input  logic [7:0] cfg_m_tiles,
  input  logic       compute_done,
  output logic       wload_state,
  output logic [9:0] wload_init_addr,
  output logic [9:0] wload_amount,
  output logic       compute_start,
  output logic       acc_first,
  output logic       acc_last,
  output logic       busy,
  output logic       layer_done
);

  localparam int TILE_ROWS = Tn * Tm;
  localparam int TW        = $clog2(LOAD_WAIT);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, NEXT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [7:0]    n_idx_reg, n_idx_next;
  logic [7:0]    m_idx_reg, m_idx_next;
  logic [7:0]    n_tiles_reg, n_tiles_next;
  logic [7:0]    m_tiles_reg, m_tiles_next;
  logic [9:0]    addr_reg, addr_next;
  logic          empty_reg, empty_next;
  logic          cs_next;

  always_comb begin
    state_next   = state_reg;
    timer_next   = '0;
    n_idx_next   = n_idx_reg;
    m_idx_next   = m_idx_reg;
    n_tiles_next = n_tiles_reg;
    m_tiles_next = m_tiles_reg;
    addr_next    = addr_reg;
    empty_next   = empty_reg;

    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_tiles_next = cfg_n_tiles;
            m_tiles_next = cfg_m_tiles;
            n_idx_next   = '0;
            m_idx_next   = '0;
            addr_next    = cfg_base_addr;
            empty_next   = (cfg_n_tiles == 8'd0) || (cfg_m_tiles == 8'd0);
            // An empty layer still spends one NEXT cycle (loader disabled)
            // so layer_done keeps a fixed two-cycle latency from start.
            state_next   = empty_next ? NEXT : LOAD;
          end
        end
        LOAD: begin
          if (timer_reg == TW'(LOAD_WAIT - 1)) begin
            state_next = COMPUTE;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        COMPUTE: begin
          if (compute_done) begin
            state_next = NEXT;
          end
        end
        NEXT: begin
          addr_next = addr_reg + 10'(TILE_ROWS);
          if (empty_reg) begin
            state_next = DONE;
          end else if (n_idx_reg < n_tiles_reg - 8'd1) begin
            n_idx_next = n_idx_reg + 8'd1;
            state_next = LOAD;
          end else if (m_idx_reg < m_tiles_reg - 8'd1) begin
            n_idx_next = '0;
            m_idx_next = m_idx_reg + 8'd1;
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulse exactly on the LOAD -> COMPUTE transition (abort forces IDLE).
  assign cs_next = (state_reg == LOAD) && (state_next == COMPUTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      n_idx_reg     <= '0;
      m_idx_reg     <= '0;
      n_tiles_reg   <= '0;
      m_tiles_reg   <= '0;
      addr_reg      <= '0;
      empty_reg     <= 1'b0;
      wload_state   <= 1'b0;
      compute_start <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      n_idx_reg     <= n_idx_next;
      m_idx_reg     <= m_idx_next;
      n_tiles_reg   <= n_tiles_next;
      m_tiles_reg   <= m_tiles_next;
      addr_reg      <= addr_next;
      empty_reg     <= empty_next;
      // Outputs are registered from the next state so they line up with it.
      wload_state   <= (state_next == LOAD) || (state_next == COMPUTE);
      compute_start <= cs_next;
      busy          <= (state_next != IDLE);
      layer_done    <= (state_next == DONE);
    end
  end

  assign wload_init_addr = addr_reg;
  assign wload_amount    = 10'(TILE_ROWS);

`ifdef WEIGHT_TILE_SCHED_ACC_FLAGS_EN
  // Flags describe the tile being started and hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
    end else if (cs_next) begin
      acc_first <= (n_idx_reg == 8'd0);
      acc_last  <= (n_idx_reg == n_tiles_reg - 8'd1);
    end
  end
`else
  assign acc_first = 1'b0;
  assign acc_last  = 1'b0;
`endif

endmodule

// File: tb/tb_weight_tile_sched.sv
// Testbench for weight_tile_sched: directed layer runs with a queue of
// expected tile addresses / accumulate flags, popped as tiles are loaded.

module tb_weight_tile_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [9:0] cfg_base_addr;
  logic [7:0] cfg_n_tiles;
  logic [7:0] cfg_m_tiles;
  logic       compute_done;
  logic       wload_state;
  logic [9:0] wload_init_addr;
  logic [9:0] wload_amount;
  logic       compute_start;
  logic       acc_first;
  logic       acc_last;
  logic       busy;
  logic       layer_done;

  weight_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_n_tiles(cfg_n_tiles),
    .cfg_m_tiles(cfg_m_tiles), .compute_done(compute_done),
    .wload_state(wload_state), .wload_init_addr(wload_init_addr),
    .wload_amount(wload_amount), .compute_start(compute_start),
    .acc_first(acc_first), .acc_last(acc_last), .busy(busy),
    .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event counters, updated on the falling edge before the main block samples.
  int   done_cnt = 0;
  int   cs_cnt   = 0;
  int   rise_cnt = 0;
  logic wl_prev  = 1'b0;
  always @(negedge clk) begin
    if (layer_done) done_cnt++;
    if (compute_start) cs_cnt++;
    if (wload_state && !wl_prev) rise_cnt++;
    wl_prev = wload_state;
  end

  int n_assert = 0;
  int n_fail   = 0;

  int         exp_addr_q[$];
  logic [1:0] exp_acc_q[$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one layer. abort_tile >= 0 aborts together with that tile's
  // compute_done; inject pulses start with other cfg during tile 0 compute.
  task automatic run_layer(input int base, input int n, input int m,
                           input int abort_tile, input bit inject);
    int tiles;
    int k;
    int rise;
    int prev_rise;
    int c;
    int d0;
    logic [1:0] ea;
    tiles = n * m;
    exp_addr_q.delete();
    exp_acc_q.delete();
    for (int t = 0; t < tiles; t++) begin
      exp_addr_q.push_back((base + t * 32) % 1024);
`ifdef WEIGHT_TILE_SCHED_ACC_FLAGS_EN
      exp_acc_q.push_back({(t % n) == 0, (t % n) == n - 1});
`else
      exp_acc_q.push_back(2'b00);
`endif
    end
    d0 = done_cnt;
    cfg_base_addr = 10'(base);
    cfg_n_tiles   = 8'(n);
    cfg_m_tiles   = 8'(m);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    prev_rise = -1;
    for (int t = 0; t < tiles; t++) begin
      k = 0;
      while (!wload_state && k < 100) begin tick(); k++; end
      chk("wload_rise_in_time", (k < 100), 1);
      rise = cyc;
      if (prev_rise >= 0) chk("tile_period", rise - prev_rise, 47);
      prev_rise = rise;
      chk("wload_init_addr", wload_init_addr, exp_addr_q.pop_front());
      k = 0;
      while (!compute_start && k < 100) begin tick(); k++; end
      chk("compute_start_delay", cyc - rise, 40);
      ea = exp_acc_q.pop_front();
      chk("acc_flags", {acc_first, acc_last}, ea);
      c = cyc;
      tick();
      chk("compute_start_pulse", compute_start, 0);
      if (inject && t == 0) begin
        cfg_base_addr = 10'd5;
        cfg_n_tiles   = 8'd7;
        cfg_m_tiles   = 8'd7;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      compute_done = 1'b1;
      abort = (t == abort_tile);
      tick();
      compute_done = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_wload", wload_state, 0);
        chk("abort_layer_done", layer_done, 0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        return;
      end
      chk("next_wload_low", wload_state, 0);
      if (t == tiles - 1) begin
        tick();
        chk("layer_done_high", layer_done, 1);
        chk("busy_in_done", busy, 1);
        tick();
        chk("layer_done_low", layer_done, 0);
        chk("busy_after_done", busy, 0);
        chk("layer_done_once", done_cnt - d0, 1);
        chk("addr_queue_drained", exp_addr_q.size(), 0);
      end
    end
  endtask

  initial begin
    int rc;
    int cc;
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    compute_done = 1'b0;
    cfg_base_addr = '0;
    cfg_n_tiles = '0;
    cfg_m_tiles = '0;
    repeat (3) tick();
    chk("rst_wload_state", wload_state, 0);
    chk("rst_init_addr", wload_init_addr, 0);
    chk("rst_amount", wload_amount, 32);
    chk("rst_compute_start", compute_start, 0);
    chk("rst_acc", {acc_first, acc_last}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_layer_done", layer_done, 0);
    rst_n = 1'b1;
    tick();

    run_layer(0, 2, 2, -1, 1'b0);      // addresses 0, 32, 64, 96
    run_layer(1000, 1, 2, -1, 1'b0);   // addresses 1000, 8 (wrap)

    // Empty layer: layer_done two cycles after start, loader never enabled.
    rc = rise_cnt;
    cc = cs_cnt;
    d0 = done_cnt;
    cfg_base_addr = 10'd50;
    cfg_n_tiles   = 8'd0;
    cfg_m_tiles   = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 1);
    chk("zero_done_early", layer_done, 0);
    tick();
    chk("zero_layer_done", layer_done, 1);
    tick();
    chk("zero_done_low", layer_done, 0);
    chk("zero_busy_low", busy, 0);
    chk("zero_no_wload", rise_cnt - rc, 0);
    chk("zero_no_cs", cs_cnt - cc, 0);
    chk("zero_done_once", done_cnt - d0, 1);

    run_layer(100, 2, 2, 2, 1'b0);     // aborted on tile 2
    run_layer(100, 1, 2, -1, 1'b0);    // restarts at base: 100, 132
    run_layer(200, 2, 1, -1, 1'b1);    // start during COMPUTE ignored
    run_layer(300, 3, 1, -1, 1'b0);    // accumulate flags over 3 input tiles

    // Asynchronous reset in the middle of a load window.
    cfg_base_addr = 10'd64;
    cfg_n_tiles   = 8'd1;
    cfg_m_tiles   = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_reset_wload", wload_state, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_wload", wload_state, 0);
    chk("async_rst_addr", wload_init_addr, 0);
    chk("async_rst_amount", wload_amount, 32);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
